// File: rtl/grf_wb.sv
// grf_wb: 32x32 general register file at write-back, with a commit trace FIFO.
// Handshake: the trace head is transferred on a rising edge where trace_valid
// and trace_ready are both high. trace_valid never depends on trace_ready.
// While trace_valid is high and trace_ready is low, the head fields hold steady.
// trace_ready is ignored while the FIFO is empty.
module grf_wb #(
  parameter int TRACE_DEPTH = 4,
  parameter bit FORWARD     = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [4:0]                     A1,
  input  logic [4:0]                     A2,
  output logic [31:0]                    RD1,
  output logic [31:0]                    RD2,
  input  logic                           RegWrite,
  input  logic [4:0]                     RegAddr,
  input  logic [31:0]                    RegData,
  input  logic [31:0]                    PC,
  output logic                           trace_valid,
  input  logic                           trace_ready,
  output logic [31:0]                    trace_pc,
  output logic [4:0]                     trace_addr,
  output logic [31:0]                    trace_data,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic                           trace_drop
);

  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 32 + 5 + 32;

  logic [31:0]   rf_q [32];
  logic [EW-1:0] trace_mem_q [TRACE_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drop_q, drop_d;

  logic          commit;
  logic          full;
  logic          pop;
  logic          do_push;
  logic [EW-1:0] head;

  // A write commits only when enabled, not to $0, and not under reset.
  assign commit  = RegWrite && (RegAddr != 5'd0) && reset;
  assign full    = (count_q == CW'(TRACE_DEPTH));
  assign pop     = trace_valid && trace_ready;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = commit && (!full || pop);

  // Register array: clear on reset, otherwise take the committed write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (commit) begin
      rf_q[RegAddr] <= RegData;
    end
  end

  // Read port 1: $0 reads zero; optional bypass of the in-flight write.
  always_comb begin
    RD1 = rf_q[A1];
    if (A1 == 5'd0) RD1 = '0;
    else if (FORWARD && commit && (A1 == RegAddr)) RD1 = RegData;
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    RD2 = rf_q[A2];
    if (A2 == 5'd0) RD2 = '0;
    else if (FORWARD && commit && (A2 == RegAddr)) RD2 = RegData;
  end

  // Trace storage: entries are only read once written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) trace_mem_q[wr_ptr_q] <= {PC, RegAddr, RegData};
  end

  // Next-state for pointers, occupancy and the sticky drop flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(do_push) - CW'(pop);
    if (commit && !do_push) drop_d = 1'b1;
  end

  // FIFO control registers; reset wins over any push or pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  assign head        = trace_mem_q[rd_ptr_q];
  assign trace_valid = (count_q != '0);
  assign trace_count = count_q;
  assign trace_drop  = drop_q;
  assign trace_pc    = trace_valid ? head[EW-1:37] : '0;
  assign trace_addr  = trace_valid ? head[36:32]   : '0;
  assign trace_data  = trace_valid ? head[31:0]    : '0;

endmodule

// File: tb/tb_grf_wb.sv
// Directed bench for grf_wb: one forwarding instance and one non-forwarding
// instance share every input.
module tb_grf_wb;

  logic        clk;
  logic        reset;
  logic [4:0]  a1, a2;
  logic        reg_write;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data, pc;
  logic        trace_ready;

  logic [31:0] rd1, rd2;
  logic        tvalid;
  logic [31:0] tpc, tdata;
  logic [4:0]  taddr;
  logic [2:0]  tcount;
  logic        tdrop;

  logic [31:0] nf_rd1, nf_rd2;
  logic        nf_tvalid;
  logic [31:0] nf_tpc, nf_tdata;
  logic [4:0]  nf_taddr;
  logic [2:0]  nf_tcount;
  logic        nf_tdrop;

  int n_checks = 0;
  int n_pass   = 0;

  grf_wb #(.TRACE_DEPTH(4), .FORWARD(1'b1)) dut (
    .clk(clk), .reset(reset), .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2),
    .RegWrite(reg_write), .RegAddr(reg_addr), .RegData(reg_data), .PC(pc),
    .trace_valid(tvalid), .trace_ready(trace_ready), .trace_pc(tpc),
    .trace_addr(taddr), .trace_data(tdata), .trace_count(tcount),
    .trace_drop(tdrop)
  );

  grf_wb #(.TRACE_DEPTH(4), .FORWARD(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .A1(a1), .A2(a2), .RD1(nf_rd1), .RD2(nf_rd2),
    .RegWrite(reg_write), .RegAddr(reg_addr), .RegData(reg_data), .PC(pc),
    .trace_valid(nf_tvalid), .trace_ready(trace_ready), .trace_pc(nf_tpc),
    .trace_addr(nf_taddr), .trace_data(nf_tdata), .trace_count(nf_tcount),
    .trace_drop(nf_tdrop)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit_w(input logic [4:0] addr, input logic [31:0] data, input logic [31:0] p);
    reg_write = 1'b1;
    reg_addr  = addr;
    reg_data  = data;
    pc        = p;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_head(input string tag, input logic [31:0] p, input logic [4:0] a, input logic [31:0] d);
    check({tag, " valid"}, {31'd0, tvalid}, 32'd1);
    check({tag, " pc"},    tpc, p);
    check({tag, " addr"},  {27'd0, taddr}, {27'd0, a});
    check({tag, " data"},  tdata, d);
  endtask

  initial begin
    reset = 1'b0; a1 = '0; a2 = '0; reg_write = 1'b0; reg_addr = '0;
    reg_data = '0; pc = '0; trace_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;

    // Reset state
    a1 = 5'd3; a2 = 5'd9; #1;
    check("rst rd1", rd1, 32'd0);
    check("rst rd2", rd2, 32'd0);
    check("rst valid", {31'd0, tvalid}, 32'd0);
    check("rst count", {29'd0, tcount}, 32'd0);
    check("rst drop", {31'd0, tdrop}, 32'd0);
    check("rst head pc", tpc, 32'd0);

    // T1: fill every register, then reset clears them
    for (int i = 0; i < 32; i++) commit_w(5'(i), 32'hA000_0000 | 32'(i), 32'h1000 + 32'(4 * i));
    a1 = 5'd31; a2 = 5'd17; #1;
    check("t1 rd1 r31", rd1, 32'hA000_001F);
    check("t1 rd2 r17", rd2, 32'hA000_0011);
    check("t1 count full", {29'd0, tcount}, 32'd4);
    check("t1 drop", {31'd0, tdrop}, 32'd1);
    check("t1 head r1", tpc, 32'h1004);
    pulse_reset();
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(31 - i); #1;
      check("t1 clr rd1", rd1, 32'd0);
      check("t1 clr rd2", rd2, 32'd0);
    end
    check("t1 valid", {31'd0, tvalid}, 32'd0);
    check("t1 count", {29'd0, tcount}, 32'd0);
    check("t1 drop clr", {31'd0, tdrop}, 32'd0);

    // T2: writes to $0 are discarded and not logged
    a1 = 5'd0;
    reg_write = 1'b1; reg_addr = 5'd0; reg_data = 32'hDEADBEEF; pc = 32'h2000; #1;
    check("t2 rd1 pre", rd1, 32'd0);
    tick();
    reg_write = 1'b0; #1;
    check("t2 rd1 post", rd1, 32'd0);
    check("t2 count", {29'd0, tcount}, 32'd0);

    // T3: forwarding vs stored value
    commit_w(5'd5, 32'h0000_AAAA, 32'h2100);
    a1 = 5'd5; a2 = 5'd5;
    reg_write = 1'b1; reg_addr = 5'd5; reg_data = 32'h1234; pc = 32'h2104; #1;
    check("t3 fwd rd1", rd1, 32'h1234);
    check("t3 fwd rd2", rd2, 32'h1234);
    check("t3 nofwd rd1", nf_rd1, 32'h0000_AAAA);
    check("t3 nofwd rd2", nf_rd2, 32'h0000_AAAA);
    tick();
    reg_write = 1'b0; #1;
    check("t3 fwd after", rd1, 32'h1234);
    check("t3 nofwd after", nf_rd1, 32'h1234);
    check("t3 count", {29'd0, tcount}, 32'd2);
    pulse_reset();

    // T4: trace ordering and handshake
    trace_ready = 1'b0;
    commit_w(5'd1, 32'h111, 32'h3000);
    commit_w(5'd2, 32'h222, 32'h3004);
    commit_w(5'd3, 32'h333, 32'h3008);
    check("t4 count", {29'd0, tcount}, 32'd3);
    check_head("t4 head0", 32'h3000, 5'd1, 32'h111);
    tick();
    check_head("t4 hold", 32'h3000, 5'd1, 32'h111);
    trace_ready = 1'b1; #1;
    check_head("t4 pop0", 32'h3000, 5'd1, 32'h111);
    tick();
    check_head("t4 pop1", 32'h3004, 5'd2, 32'h222);
    check("t4 count2", {29'd0, tcount}, 32'd2);
    tick();
    check_head("t4 pop2", 32'h3008, 5'd3, 32'h333);
    tick();
    check("t4 empty valid", {31'd0, tvalid}, 32'd0);
    check("t4 empty pc", tpc, 32'd0);
    check("t4 empty data", tdata, 32'd0);
    tick();
    check("t4 ready empty count", {29'd0, tcount}, 32'd0);
    trace_ready = 1'b0;
    pulse_reset();

    // T5: overflow, then full + push + pop
    for (int i = 1; i <= 5; i++) commit_w(5'(i), 32'h50 + 32'(i), 32'h4000 + 32'(4 * (i - 1)));
    check("t5 count", {29'd0, tcount}, 32'd4);
    check("t5 drop", {31'd0, tdrop}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      a1 = 5'(i); #1;
      check("t5 reg", rd1, 32'h50 + 32'(i));
    end
    trace_ready = 1'b1;
    reg_write = 1'b1; reg_addr = 5'd6; reg_data = 32'h66; pc = 32'h4014; #1;
    check_head("t5 head0", 32'h4000, 5'd1, 32'h51);
    tick();
    reg_write = 1'b0; #1;
    check("t5 pushpop count", {29'd0, tcount}, 32'd4);
    check("t5 pushpop drop", {31'd0, tdrop}, 32'd1);
    check_head("t5 head1", 32'h4004, 5'd2, 32'h52);
    tick();
    check_head("t5 head2", 32'h4008, 5'd3, 32'h53);
    tick();
    check_head("t5 head3", 32'h400C, 5'd4, 32'h54);
    tick();
    check_head("t5 head4", 32'h4014, 5'd6, 32'h66);
    tick();
    check("t5 drained", {31'd0, tvalid}, 32'd0);
    trace_ready = 1'b0;
    pulse_reset();
    check("t5 drop after rst", {31'd0, tdrop}, 32'd0);

    // T6: reset concurrent with a commit
    commit_w(5'd1, 32'h71, 32'h5000);
    commit_w(5'd2, 32'h72, 32'h5004);
    check("t6 count2", {29'd0, tcount}, 32'd2);
    reset = 1'b0;
    reg_write = 1'b1; reg_addr = 5'd7; reg_data = 32'h77; pc = 32'h5008;
    a1 = 5'd7; #1;
    check("t6 no fwd in rst", rd1, 32'd0);
    tick();
    reset = 1'b1; reg_write = 1'b0;
    a1 = 5'd7; a2 = 5'd1; #1;
    check("t6 r7", rd1, 32'd0);
    check("t6 r1", rd2, 32'd0);
    check("t6 count", {29'd0, tcount}, 32'd0);
    check("t6 valid", {31'd0, tvalid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
